// File: rtl/mem_wb_pkg.sv
// Shared definitions for the MEM/WB stage: bus types, load-type codes, stall-bit
// positions and the layout of the write-back register.
package defines;

    typedef logic [31:0] RegBus;
    typedef logic [4:0]  RegAddrBus;

    localparam RegBus ZeroWord = 32'h0000_0000;

    localparam int unsigned LOAD_NONE = 0;
    localparam int unsigned LOAD_LB   = 1;
    localparam int unsigned LOAD_LBU  = 2;
    localparam int unsigned LOAD_LH   = 3;
    localparam int unsigned LOAD_LHU  = 4;
    localparam int unsigned LOAD_LW   = 5;
    localparam int unsigned LOAD_LWL  = 6;
    localparam int unsigned LOAD_LWR  = 7;

    localparam int unsigned STALL_MEM = 4;
    localparam int unsigned STALL_WB  = 5;

    typedef struct packed {
        logic      wen;
        RegAddrBus waddr;
        RegBus     wdata;
        logic      whilo;
        RegBus     hi;
        RegBus     lo;
        logic      adel;
    } wb_regs_t;

endpackage

// File: rtl/mem_wb_if.sv
// MEM -> WB boundary bus: pipeline control, MEM-stage results and the
// registered write-back outputs.
interface mem_wb_if
    import defines::*;
#(
    parameter int LOAD_W = 3
) ();

    logic [5:0]        stall;
    logic              flush;
    logic              mem_wen;
    RegAddrBus         mem_waddr;
    RegBus             mem_wdata;
    logic [LOAD_W-1:0] mem_load;
    logic [1:0]        mem_addr_lo;
    RegBus             dm_rdata;
    logic              mem_whilo;
    RegBus             mem_hi;
    RegBus             mem_lo;

    logic              wb_wen;
    RegAddrBus         wb_waddr;
    RegBus             wb_wdata;
    logic              wb_whilo;
    RegBus             wb_hi;
    RegBus             wb_lo;
    logic              wb_adel;

    modport master (
        output stall, flush, mem_wen, mem_waddr, mem_wdata, mem_load, mem_addr_lo,
               dm_rdata, mem_whilo, mem_hi, mem_lo,
        input  wb_wen, wb_waddr, wb_wdata, wb_whilo, wb_hi, wb_lo, wb_adel
    );

    modport slave (
        input  stall, flush, mem_wen, mem_waddr, mem_wdata, mem_load, mem_addr_lo,
               dm_rdata, mem_whilo, mem_hi, mem_lo,
        output wb_wen, wb_waddr, wb_wdata, wb_whilo, wb_hi, wb_lo, wb_adel
    );

endinterface

// File: rtl/mem_wb_load_align.sv
// Big-endian load extraction with sign/zero extension and misalignment detection.
// LWL/LWR merging is built only when MEM_WB_UNALIGNED_EN is defined.
module load_align
    import defines::*;
#(
    parameter int LOAD_W = 3
) (
    input  logic [LOAD_W-1:0] mem_load,
    input  logic [1:0]        addr_lo,
    input  RegBus             dm_rdata,
    input  RegBus             rt,
    output RegBus             data,
    output logic              misalign
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Byte 0 is the most significant byte of the read word.
    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = dm_rdata[31:24];
            2'd1:    byte_sel = dm_rdata[23:16];
            2'd2:    byte_sel = dm_rdata[15:8];
            default: byte_sel = dm_rdata[7:0];
        endcase
        half_sel = addr_lo[1] ? dm_rdata[15:0] : dm_rdata[31:16];
    end

`ifdef MEM_WB_UNALIGNED_EN
    RegBus lwl_word;
    RegBus lwr_word;

    always_comb begin
        case (addr_lo)
            2'd0:    lwl_word = dm_rdata;
            2'd1:    lwl_word = {dm_rdata[23:0], rt[7:0]};
            2'd2:    lwl_word = {dm_rdata[15:0], rt[15:0]};
            default: lwl_word = {dm_rdata[7:0],  rt[23:0]};
        endcase
        case (addr_lo)
            2'd0:    lwr_word = {rt[31:8],  dm_rdata[31:24]};
            2'd1:    lwr_word = {rt[31:16], dm_rdata[31:16]};
            2'd2:    lwr_word = {rt[31:24], dm_rdata[31:8]};
            default: lwr_word = dm_rdata;
        endcase
    end
`endif

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        data     = rt;
        misalign = 1'b0;
        case (mem_load)
            LOAD_W'(LOAD_LB):  data = {{24{byte_sel[7]}}, byte_sel};
            LOAD_W'(LOAD_LBU): data = {24'h0, byte_sel};
            LOAD_W'(LOAD_LH),
            LOAD_W'(LOAD_LHU): begin
                if (addr_lo[0]) begin
                    misalign = 1'b1;
                    data     = ZeroWord;
                end else if (mem_load == LOAD_W'(LOAD_LH)) begin
                    data = {{16{half_sel[15]}}, half_sel};
                end else begin
                    data = {16'h0, half_sel};
                end
            end
            LOAD_W'(LOAD_LW): begin
                if (addr_lo != 2'd0) begin
                    misalign = 1'b1;
                    data     = ZeroWord;
                end else begin
                    data = dm_rdata;
                end
            end
`ifdef MEM_WB_UNALIGNED_EN
            LOAD_W'(LOAD_LWL): data = lwl_word;
            LOAD_W'(LOAD_LWR): data = lwr_word;
`endif
            default: data = rt;
        endcase
    end

endmodule

// File: rtl/mem_wb.sv
// MEM/WB pipeline register: captures MEM results and load data, applies the
// flush/stall protocol. Optional LWL/LWR support via MEM_WB_UNALIGNED_EN.
module mem_wb
    import defines::*;
#(
    parameter int LOAD_W = 3
) (
    input  logic     clk,
    input  logic     rst,
    mem_wb_if.slave  bus
);

    RegBus    load_data;
    logic     misalign;
    wb_regs_t nxt;
    wb_regs_t q;

    load_align #(.LOAD_W(LOAD_W)) u_load_align (
        .mem_load (bus.mem_load),
        .addr_lo  (bus.mem_addr_lo),
        .dm_rdata (bus.dm_rdata),
        .rt       (bus.mem_wdata),
        .data     (load_data),
        .misalign (misalign)
    );

    // A misaligned load becomes an address-error marker instead of a write.
    assign nxt = '{
        wen:   bus.mem_wen & ~misalign,
        waddr: bus.mem_waddr,
        wdata: load_data,
        whilo: bus.mem_whilo,
        hi:    bus.mem_hi,
        lo:    bus.mem_lo,
        adel:  misalign
    };

    // MEM stalled while WB runs means WB must see a bubble, not a repeat.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (rst) begin
            q <= '0;
        end else if (bus.flush) begin
            q <= '0;
        end else if (bus.stall[STALL_MEM] && !bus.stall[STALL_WB]) begin
            q <= '0;
        end else if (!bus.stall[STALL_MEM]) begin
            q <= nxt;
        end
    end

    assign bus.wb_wen   = q.wen;
    assign bus.wb_waddr = q.waddr;
    assign bus.wb_wdata = q.wdata;
    assign bus.wb_whilo = q.whilo;
    assign bus.wb_hi    = q.hi;
    assign bus.wb_lo    = q.lo;
    assign bus.wb_adel  = q.adel;

endmodule

// File: tb/tb_mem_wb.sv
// Self-checking bench for mem_wb: load-extraction vector table, stall/flush/reset
// sequences and randomized traffic against a byte-level reference model.
module tb_mem_wb;

    typedef struct {
        logic        wen;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        whilo;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        adel;
    } wb_t;

    typedef struct {
        logic [2:0]  load;
        logic [1:0]  addr_lo;
        logic [31:0] dm;
        logic [31:0] rt;
        logic [31:0] exp_data;
        logic        exp_wen;
        logic        exp_adel;
    } vec_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    mem_wb_if #(.LOAD_W(3)) bus ();

    mem_wb #(.LOAD_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", name, actual, expected);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic wen, input logic [4:0] waddr, input logic [31:0] wdata,
                         input logic [2:0] load, input logic [1:0] addr_lo, input logic [31:0] dm);
        bus.mem_wen     = wen;
        bus.mem_waddr   = waddr;
        bus.mem_wdata   = wdata;
        bus.mem_load    = load;
        bus.mem_addr_lo = addr_lo;
        bus.dm_rdata    = dm;
    endtask

    // Reference: memory viewed as a byte array, byte 0 at the lowest address.
    function automatic wb_t ref_capture(input logic wen, input logic [4:0] waddr,
                                        input logic [31:0] rt, input logic [2:0] load,
                                        input logic [1:0] addr_lo, input logic [31:0] dm,
                                        input logic whilo, input logic [31:0] hi,
                                        input logic [31:0] lo);
        logic [7:0]  b [4];
        logic [15:0] half;
        logic [63:0] mask;
        wb_t r;
        int k;
        k = int'(addr_lo);
        for (int i = 0; i < 4; i++) b[i] = dm[31 - 8*i -: 8];
        r.wen = wen; r.waddr = waddr; r.whilo = whilo; r.hi = hi; r.lo = lo;
        r.adel = 1'b0;
        r.wdata = rt;
        case (load)
            3'd1: r.wdata = {{24{b[k][7]}}, b[k]};
            3'd2: r.wdata = {24'h0, b[k]};
            3'd3, 3'd4: begin
                if (k % 2 != 0) r.adel = 1'b1;
                else begin
                    half = {b[k], b[k+1]};
                    r.wdata = (load == 3'd3) ? {{16{half[15]}}, half} : {16'h0, half};
                end
            end
            3'd5: if (k != 0) r.adel = 1'b1; else r.wdata = dm;
`ifdef MEM_WB_UNALIGNED_EN
            3'd6: begin
                mask = (64'd1 << (8*k)) - 64'd1;
                r.wdata = 32'(({32'h0, dm} << (8*k)) | ({32'h0, rt} & mask));
            end
            3'd7: begin
                mask = (64'd1 << (8*(k+1))) - 64'd1;
                r.wdata = 32'(({32'h0, dm} >> (8*(3-k))) | ({32'h0, rt} & ~mask));
            end
`endif
            default: r.wdata = rt;
        endcase
        if (r.adel) begin
            r.wen = 1'b0;
            r.wdata = 32'h0;
        end
        return r;
    endfunction

    task automatic check_all(input string tag, input wb_t e);
        check({tag, "_wdata"}, bus.wb_wdata, e.wdata);
        check({tag, "_ctl"}, {24'h0, bus.wb_wen, bus.wb_waddr, bus.wb_whilo, bus.wb_adel},
              {24'h0, e.wen, e.waddr, e.whilo, e.adel});
        check({tag, "_hi"}, bus.wb_hi, e.hi);
        check({tag, "_lo"}, bus.wb_lo, e.lo);
    endtask

    initial begin
        vec_t vecs[$];
        wb_t  zero_wb;
        wb_t  exp;
        wb_t  cand;
        n_checks = 0;
        n_pass   = 0;
        zero_wb  = '{default: '0};
        clk = 1'b0;
        rst = 1'b1;

        // Reset with busy inputs: everything must read zero, even across an edge.
        bus.stall = 6'b0; bus.flush = 1'b0;
        bus.mem_whilo = 1'b1; bus.mem_hi = 32'hDEAD_BEEF; bus.mem_lo = 32'h1234_5678;
        drive(1'b1, 5'd9, 32'hFFFF_FFFF, 3'd5, 2'd0, 32'hCAFE_BABE);
        #12;
        check_all("reset", zero_wb);

        // First capture after release.
        rst = 1'b0;
        bus.mem_whilo = 1'b0; bus.mem_hi = 32'h0; bus.mem_lo = 32'h0;
        drive(1'b1, 5'd3, 32'h0000_1234, 3'd0, 2'd0, 32'h0);
        step();
        check("first_wen", {31'h0, bus.wb_wen}, 32'd1);
        check("first_waddr", {27'h0, bus.wb_waddr}, 32'd3);
        check("first_wdata", bus.wb_wdata, 32'h0000_1234);

        // Load-extraction vectors.
        vecs.push_back('{3'd1, 2'd0, 32'h80FF7F01, 32'h0, 32'hFFFFFF80, 1'b1, 1'b0});
        vecs.push_back('{3'd2, 2'd1, 32'h80FF7F01, 32'h0, 32'h000000FF, 1'b1, 1'b0});
        vecs.push_back('{3'd3, 2'd2, 32'h80FF7F01, 32'h0, 32'h00007F01, 1'b1, 1'b0});
        vecs.push_back('{3'd5, 2'd0, 32'h80FF7F01, 32'h0, 32'h80FF7F01, 1'b1, 1'b0});
        vecs.push_back('{3'd5, 2'd2, 32'h80FF7F01, 32'h0, 32'h00000000, 1'b0, 1'b1});
        vecs.push_back('{3'd4, 2'd0, 32'h80FF7F01, 32'h0, 32'h000080FF, 1'b1, 1'b0});
        vecs.push_back('{3'd3, 2'd0, 32'h80FF7F01, 32'h0, 32'hFFFF80FF, 1'b1, 1'b0});
        vecs.push_back('{3'd1, 2'd3, 32'h80FF7F01, 32'h0, 32'h00000001, 1'b1, 1'b0});
        vecs.push_back('{3'd3, 2'd1, 32'h80FF7F01, 32'h0, 32'h00000000, 1'b0, 1'b1});
        vecs.push_back('{3'd0, 2'd3, 32'h80FF7F01, 32'hCAFEF00D, 32'hCAFEF00D, 1'b1, 1'b0});
`ifdef MEM_WB_UNALIGNED_EN
        vecs.push_back('{3'd6, 2'd1, 32'h11223344, 32'hAABBCCDD, 32'h223344DD, 1'b1, 1'b0});
        vecs.push_back('{3'd7, 2'd1, 32'h11223344, 32'hAABBCCDD, 32'hAABB1122, 1'b1, 1'b0});
        vecs.push_back('{3'd6, 2'd3, 32'h11223344, 32'hAABBCCDD, 32'h44BBCCDD, 1'b1, 1'b0});
        vecs.push_back('{3'd7, 2'd3, 32'h11223344, 32'hAABBCCDD, 32'h11223344, 1'b1, 1'b0});
`else
        vecs.push_back('{3'd6, 2'd1, 32'h11223344, 32'hAABBCCDD, 32'hAABBCCDD, 1'b1, 1'b0});
        vecs.push_back('{3'd7, 2'd2, 32'h11223344, 32'hAABBCCDD, 32'hAABBCCDD, 1'b1, 1'b0});
`endif
        foreach (vecs[i]) begin
            drive(1'b1, 5'(i + 1), vecs[i].rt, vecs[i].load, vecs[i].addr_lo, vecs[i].dm);
            step();
            check($sformatf("vec%0d_data", i), bus.wb_wdata, vecs[i].exp_data);
            check($sformatf("vec%0d_flags", i), {30'h0, bus.wb_wen, bus.wb_adel},
                  {30'h0, vecs[i].exp_wen, vecs[i].exp_adel});
        end

        // Hold for three cycles while inputs keep changing.
        drive(1'b1, 5'd7, 32'h0000_0077, 3'd0, 2'd0, 32'h0);
        step();
        bus.stall = 6'b110000;
        drive(1'b1, 5'd9, 32'h0000_0099, 3'd0, 2'd0, 32'h0);
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("hold%0d_wdata", c), bus.wb_wdata, 32'h0000_0077);
            check($sformatf("hold%0d_waddr", c), {27'h0, bus.wb_waddr}, 32'd7);
        end
        // MEM stalled, WB free: bubble.
        bus.stall = 6'b010000;
        step();
        check_all("bubble", zero_wb);
        bus.stall = 6'b0;
        step();
        check("resume_wdata", bus.wb_wdata, 32'h0000_0099);
        // Flush beats a full hold.
        bus.stall = 6'b110000;
        bus.flush = 1'b1;
        step();
        check_all("flush", zero_wb);
        bus.flush = 1'b0;
        bus.stall = 6'b0;

        // Reset in the middle of a hold leaves nothing behind.
        drive(1'b1, 5'd5, 32'h0000_0055, 3'd0, 2'd0, 32'h0);
        step();
        bus.stall = 6'b110000;
        step();
        check("pre_rst_hold", bus.wb_wdata, 32'h0000_0055);
        #2 rst = 1'b1;
        #1;
        check_all("async_rst", zero_wb);
        #1 rst = 1'b0;
        step();
        check_all("post_rst_hold", zero_wb);
        bus.stall = 6'b0;

        // Randomized traffic against the reference model, starting from reset.
        rst = 1'b1;
        #2 rst = 1'b0;
        exp = zero_wb;
        for (int c = 0; c < 400; c++) begin
            drive(1'($urandom), 5'($urandom), $urandom, 3'($urandom), 2'($urandom), $urandom);
            bus.mem_whilo = 1'($urandom);
            bus.mem_hi    = $urandom;
            bus.mem_lo    = $urandom;
            bus.stall     = 6'($urandom);
            bus.flush     = ($urandom_range(0, 7) == 0);
            cand = ref_capture(bus.mem_wen, bus.mem_waddr, bus.mem_wdata, bus.mem_load,
                               bus.mem_addr_lo, bus.dm_rdata, bus.mem_whilo, bus.mem_hi,
                               bus.mem_lo);
            if (bus.flush) exp = zero_wb;
            else if (!bus.stall[4]) exp = cand;
            else if (!bus.stall[5]) exp = zero_wb;
            step();
            check_all($sformatf("rnd%0d", c), exp);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
